key_sw_ctrl: RTL and testbench
==============================

KEY_SW_CTRL -- requirements
Module: key_sw_ctrl

Interface
REQ-001 SHALL have parameter DBITS, default 16, data/address bus width.
REQ-002 SHALL have parameter TICK_CYCLES, default 250000, CLK cycles between debounce samples (5 ms at 50 MHz); legal range 2..2^20.
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port KEY  input  4  raw board keys, active-low (0 = pressed), asynchronous to CLK.
REQ-006 SHALL have port SW  input  10  raw board switches, asynchronous to CLK.
REQ-007 SHALL have port ADDR  input  DBITS  CPU data-memory address; bit 0 ignored.
REQ-008 SHALL have port DIN  input  DBITS  CPU store data.
REQ-009 SHALL have port WE  input  1  CPU store strobe, one cycle per store.
REQ-010 SHALL have port RE  input  1  CPU load strobe, one cycle per load.
REQ-011 SHALL have port DOUT  output  DBITS  read data, combinational from ADDR and registers.
REQ-012 SHALL have port SEL  output  1  high when ADDR decodes to a register of this block.

Function
REQ-013 Register map (ADDR with bit 0 ignored): 0xF000 KDATA, 0xF004 KCTRL, 0xF010 SDATA, 0xF014 SCTRL.
REQ-014 KDATA[3:0] SHALL hold debounced key state, active-high (1 = pressed); upper bits read 0.
REQ-015 KCTRL SHALL have bit 0 RDY and bit 1 OVR; upper bits read 0.
REQ-016 SDATA[9:0] SHALL hold debounced switch state; upper bits read 0.
REQ-017 SCTRL SHALL have bit 0 RDY and bit 1 OVR, with the same semantics as KCTRL.
REQ-018 On an unmapped ADDR, DOUT SHALL be 0 and SEL 0.
REQ-019 Each KEY and SW bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-020 A free-running prescaler SHALL count 0..TICK_CYCLES-1 and assert a one-cycle tick at count TICK_CYCLES-1, then wrap to 0.
REQ-021 On each tick, each bit SHALL sample its synchronised value; the debounced bit updates only when two consecutive tick samples agree and differ from the current debounced value.
REQ-022 Key event: any debounced key bit 0->1 (press). Release SHALL NOT be an event.
REQ-023 Switch event: any debounced switch bit change, in either direction.
REQ-024 On an event: if RDY=0, set RDY; if RDY=1, set OVR and keep RDY=1.
REQ-025 RE with ADDR=KDATA (or SDATA) SHALL clear the matching RDY at the next edge.
REQ-026 WE to KCTRL (or SCTRL) with DIN[1]=1 SHALL clear the matching OVR; DIN[0]=1 SHALL clear RDY. This is write-1-to-clear.
REQ-027 If an event and a clearing read/write of the same flag occur in the same cycle, the event SHALL win: RDY=1, and OVR is unchanged by that event.
REQ-028 WE to KDATA or SDATA SHALL have no effect.
REQ-029 Status and data SHALL be visible on DOUT in the cycle after the updating edge.

Reset
REQ-030 RESET_N=0 SHALL asynchronously clear the prescaler, synchronisers, tick samples, KDATA, SDATA, and all RDY/OVR flags to 0.
REQ-031 Release of RESET_N SHALL resume the prescaler from 0.
REQ-032 Nonzero switches at reset release SHALL produce a switch event at their first debounce update.
REQ-033 Reset asserted mid-debounce SHALL discard the pending sample.

Configuration
REQ-034 Macro KEY_SW_CTRL_SW_EVENT_EN SHALL control switch events.
REQ-035 With KEY_SW_CTRL_SW_EVENT_EN defined: REQ-023 through REQ-027 apply to SCTRL.
REQ-036 Without it: SCTRL reads 0, writes to SCTRL are ignored, and SDATA debouncing still operates.

Verification
REQ-037 TICK_CYCLES=4; hold KEY=4'b1110 for 12 cycles -> KDATA=0x0001 and KCTRL=0x0001 within 12 cycles.
REQ-038 Glitch: KEY[0] low for 3 cycles only -> KDATA and KCTRL remain 0.
REQ-039 Two debounced presses with no read -> KCTRL=0x0003; WE to 0xF004 with DIN=0x0002 -> KCTRL=0x0001; RE on 0xF000 -> KCTRL=0x0000.
REQ-040 RE on 0xF000 in the same cycle as a new press event -> KCTRL=0x0001 afterwards.
REQ-041 SW=10'h155 held -> SDATA=0x0155 and SCTRL=0x0001 (macro defined) or 0x0000 (macro undefined); ADDR=0x1000 -> SEL=0, DOUT=0.
REQ-042 RESET_N pulsed low mid-debounce -> all registers 0 immediately, with no event generated from the pre-reset samples.

Source files
------------

// File: rtl/key_sw_ctrl.sv
// key_sw_ctrl: debounced board keys/switches behind a memory-mapped status block.
// Define KEY_SW_CTRL_SW_EVENT_EN to raise SCTRL ready/overrun on switch changes.

module key_sw_ctrl #(
    parameter int DBITS       = 16,
    parameter int TICK_CYCLES = 250000
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    input  logic [DBITS-1:0] ADDR,
    input  logic [DBITS-1:0] DIN,
    input  logic             WE,
    input  logic             RE,
    output logic [DBITS-1:0] DOUT,
    output logic             SEL
);

    localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_CYCLES - 1);

    localparam logic [DBITS-1:0] A_KDATA = DBITS'(32'hF000);
    localparam logic [DBITS-1:0] A_KCTRL = DBITS'(32'hF004);
    localparam logic [DBITS-1:0] A_SDATA = DBITS'(32'hF010);
    localparam logic [DBITS-1:0] A_SCTRL = DBITS'(32'hF014);

    // Returns {ovr, rdy}; an event always wins over a same-cycle RDY clear.
    function automatic logic [1:0] flag_next(
        input logic ev,
        input logic rdy,
        input logic ovr,
        input logic clr_rdy,
        input logic clr_ovr
    );
        logic r;
        logic o;
        r = rdy & ~clr_rdy;
        o = ovr & ~clr_ovr;
        if (ev) begin
            if (rdy && !clr_rdy) begin
                o = 1'b1;
            end
            r = 1'b1;
        end
        return {o, r};
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;

    logic [3:0] key_s1_q, key_s2_q;
    logic [3:0] key_smp_q, key_smp_d;
    logic [3:0] key_deb_q, key_deb_d;
    logic [9:0] sw_s1_q, sw_s2_q;
    logic [9:0] sw_smp_q, sw_smp_d;
    logic [9:0] sw_deb_q, sw_deb_d;

    logic krdy_q, krdy_d;
    logic kovr_q, kovr_d;

    logic [DBITS-1:0] addr_w;
    logic hit_kdata, hit_kctrl, hit_sdata, hit_sctrl;
    logic key_evt;
    logic k_clr_rdy, k_clr_ovr;
    logic [DBITS-1:0] unused_din;

    assign unused_din = DIN;

    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    // A bit follows its sample only when two consecutive tick samples agree.
    always_comb begin
        key_smp_d = key_smp_q;
        key_deb_d = key_deb_q;
        sw_smp_d  = sw_smp_q;
        sw_deb_d  = sw_deb_q;
        if (tick) begin
            key_smp_d = key_s2_q;
            sw_smp_d  = sw_s2_q;
            key_deb_d = (key_s2_q & ~(key_s2_q ^ key_smp_q))
                      | (key_deb_q & (key_s2_q ^ key_smp_q));
            sw_deb_d  = (sw_s2_q & ~(sw_s2_q ^ sw_smp_q))
                      | (sw_deb_q & (sw_s2_q ^ sw_smp_q));
        end
    end

    always_comb begin
        addr_w    = ADDR & ~DBITS'(1);
        hit_kdata = (addr_w == A_KDATA);
        hit_kctrl = (addr_w == A_KCTRL);
        hit_sdata = (addr_w == A_SDATA);
        hit_sctrl = (addr_w == A_SCTRL);
        SEL       = hit_kdata | hit_kctrl | hit_sdata | hit_sctrl;
    end

    always_comb begin
        key_evt   = |(key_deb_d & ~key_deb_q);
        k_clr_rdy = (RE && hit_kdata) || (WE && hit_kctrl && DIN[0]);
        k_clr_ovr = WE && hit_kctrl && DIN[1];
        {kovr_d, krdy_d} = flag_next(key_evt, krdy_q, kovr_q,
                                     k_clr_rdy, k_clr_ovr);
    end

`ifdef KEY_SW_CTRL_SW_EVENT_EN
    logic srdy_q, srdy_d;
    logic sovr_q, sovr_d;
    logic sw_evt;
    logic s_clr_rdy, s_clr_ovr;

    always_comb begin
        sw_evt    = |(sw_deb_d ^ sw_deb_q);
        s_clr_rdy = (RE && hit_sdata) || (WE && hit_sctrl && DIN[0]);
        s_clr_ovr = WE && hit_sctrl && DIN[1];
        {sovr_d, srdy_d} = flag_next(sw_evt, srdy_q, sovr_q,
                                     s_clr_rdy, s_clr_ovr);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            srdy_q <= 1'b0;
            sovr_q <= 1'b0;
        end else begin
            srdy_q <= srdy_d;
            sovr_q <= sovr_d;
        end
    end

    logic [DBITS-1:0] sctrl_rd;
    assign sctrl_rd = DBITS'({sovr_q, srdy_q});
`else
    logic [DBITS-1:0] sctrl_rd;
    assign sctrl_rd = '0;
`endif

    always_comb begin
        DOUT = '0;
        unique case (1'b1)
            hit_kdata: DOUT = DBITS'(key_deb_q);
            hit_kctrl: DOUT = DBITS'({kovr_q, krdy_q});
            hit_sdata: DOUT = DBITS'(sw_deb_q);
            hit_sctrl: DOUT = sctrl_rd;
            default:   DOUT = '0;
        endcase
    end

    // Keys are inverted at the synchroniser so everything downstream is active-high.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q     <= '0;
            key_s1_q  <= '0;
            key_s2_q  <= '0;
            key_smp_q <= '0;
            key_deb_q <= '0;
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            sw_smp_q  <= '0;
            sw_deb_q  <= '0;
            krdy_q    <= 1'b0;
            kovr_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            key_s1_q  <= ~KEY;
            key_s2_q  <= key_s1_q;
            key_smp_q <= key_smp_d;
            key_deb_q <= key_deb_d;
            sw_s1_q   <= SW;
            sw_s2_q   <= sw_s1_q;
            sw_smp_q  <= sw_smp_d;
            sw_deb_q  <= sw_deb_d;
            krdy_q    <= krdy_d;
            kovr_q    <= kovr_d;
        end
    end

endmodule

// File: tb/tb_key_sw_ctrl.sv
// tb_key_sw_ctrl: directed and random checks of key_sw_ctrl against a behavioural model.
// Honours KEY_SW_CTRL_SW_EVENT_EN for the expected SCTRL contents.

module tb_key_sw_ctrl;

    localparam int T = 4;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [15:0] ADDR;
    logic [15:0] DIN;
    logic        WE;
    logic        RE;
    logic [15:0] DOUT;
    logic        SEL;

    int nchk = 0;
    int nerr = 0;

    key_sw_ctrl #(.DBITS(16), .TICK_CYCLES(T)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .KEY(KEY), .SW(SW),
        .ADDR(ADDR), .DIN(DIN), .WE(WE), .RE(RE),
        .DOUT(DOUT), .SEL(SEL)
    );

    always #5 CLK = ~CLK;

`ifdef KEY_SW_CTRL_SW_EVENT_EN
    localparam bit SWEV = 1'b1;
`else
    localparam bit SWEV = 1'b0;
`endif

    // Model: raw inputs reach the debouncer two edges late; ticks every T edges.
    logic [3:0] m_kq[$];
    logic [9:0] m_sq[$];
    int         m_cyc;
    logic [3:0] m_kprev, m_kdeb;
    logic [9:0] m_sprev, m_sdeb;
    logic       m_krdy, m_kovr, m_srdy, m_sovr;

    function automatic void m_reset();
        m_kq.delete();
        m_sq.delete();
        m_cyc = 0;
        m_kprev = '0; m_kdeb = '0;
        m_sprev = '0; m_sdeb = '0;
        m_krdy = 0; m_kovr = 0; m_srdy = 0; m_sovr = 0;
    endfunction

    function automatic void m_flag(input bit ev, input bit rd_clr,
                                   input bit wr, inout logic rdy, inout logic ovr);
        bit clr_r, clr_o, old_r;
        clr_r = rd_clr || (wr && DIN[0]);
        clr_o = wr && DIN[1];
        old_r = rdy;
        rdy = rdy && !clr_r;
        ovr = ovr && !clr_o;
        if (ev) begin
            if (old_r && !clr_r) ovr = 1'b1;
            rdy = 1'b1;
        end
    endfunction

    function automatic void m_edge();
        logic [3:0] ks, kold;
        logic [9:0] ss, sold;
        logic [15:0] a;
        bit tk;
        ks = (m_kq.size() == 2) ? m_kq[0] : 4'h0;
        ss = (m_sq.size() == 2) ? m_sq[0] : 10'h0;
        m_kq.push_back(~KEY);
        m_sq.push_back(SW);
        if (m_kq.size() > 2) void'(m_kq.pop_front());
        if (m_sq.size() > 2) void'(m_sq.pop_front());
        tk = (m_cyc % T) == T - 1;
        m_cyc++;
        kold = m_kdeb;
        sold = m_sdeb;
        if (tk) begin
            for (int i = 0; i < 4; i++)
                if (ks[i] == m_kprev[i]) m_kdeb[i] = ks[i];
            for (int i = 0; i < 10; i++)
                if (ss[i] == m_sprev[i]) m_sdeb[i] = ss[i];
            m_kprev = ks;
            m_sprev = ss;
        end
        a = ADDR & 16'hFFFE;
        m_flag((m_kdeb & ~kold) != 0, RE && a == 16'hF000,
               WE && a == 16'hF004, m_krdy, m_kovr);
        if (SWEV)
            m_flag(m_sdeb != sold, RE && a == 16'hF010,
                   WE && a == 16'hF014, m_srdy, m_sovr);
    endfunction

    function automatic bit m_key_ev_next();
        logic [3:0] ks;
        ks = (m_kq.size() == 2) ? m_kq[0] : 4'h0;
        return ((m_cyc % T) == T - 1) && ((ks & m_kprev & ~m_kdeb) != 0);
    endfunction

    function automatic logic [15:0] m_rd(input logic [15:0] addr);
        case (addr & 16'hFFFE)
            16'hF000: return {12'h0, m_kdeb};
            16'hF004: return {14'h0, m_kovr, m_krdy};
            16'hF010: return {6'h0, m_sdeb};
            16'hF014: return SWEV ? {14'h0, m_sovr, m_srdy} : 16'h0;
            default:  return 16'h0;
        endcase
    endfunction

    function automatic bit m_sel(input logic [15:0] addr);
        logic [15:0] a;
        a = addr & 16'hFFFE;
        return a == 16'hF000 || a == 16'hF004 || a == 16'hF010 || a == 16'hF014;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            if (RESET_N) m_edge();
            #1;
        end
    endtask

    task automatic peek(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        ADDR = addr; RE = 0; WE = 0;
        #1;
        chk(tag, DOUT, exp);
        chk({tag, "_model"}, DOUT, m_rd(addr));
    endtask

    task automatic do_reset();
        RESET_N = 0;
        m_reset();
    endtask

    logic [15:0] addrs[8] = '{16'hF000, 16'hF001, 16'hF004, 16'hF005,
                              16'hF010, 16'hF014, 16'h1000, 16'hF008};

    initial begin
        bit found;
        KEY = 4'hF; SW = 0; ADDR = 0; DIN = 0; WE = 0; RE = 0;
        do_reset();
        cycle(2);
        peek("rst_kdata", 16'hF000, 16'h0);
        peek("rst_kctrl", 16'hF004, 16'h0);
        peek("rst_sdata", 16'hF010, 16'h0);
        peek("rst_sctrl", 16'hF014, 16'h0);
        chk("rst_sel", SEL, 1'b1);
        RESET_N = 1;

        KEY = 4'b1110;
        cycle(12);
        peek("press_kdata", 16'hF000, 16'h0001);
        peek("press_kctrl", 16'hF004, 16'h0001);

        KEY = 4'hF;
        cycle(12);
        peek("release_kdata", 16'hF000, 16'h0000);
        peek("release_kctrl", 16'hF004, 16'h0001);
        KEY = 4'b1110;
        cycle(12);
        peek("ovr_kctrl", 16'hF004, 16'h0003);
        ADDR = 16'hF000; WE = 1; DIN = 16'hFFFF;
        cycle();
        WE = 0;
        peek("we_kdata_noeff", 16'hF000, 16'h0001);
        ADDR = 16'hF004; WE = 1; DIN = 16'h0002;
        cycle();
        WE = 0;
        peek("w1c_ovr", 16'hF004, 16'h0001);
        ADDR = 16'hF000; RE = 1;
        cycle();
        RE = 0;
        peek("re_clr_rdy", 16'hF004, 16'h0000);

        KEY = 4'hF;
        cycle(12);
        KEY = 4'b1110;
        cycle(3);
        KEY = 4'hF;
        cycle(12);
        peek("glitch_kdata", 16'hF000, 16'h0000);
        peek("glitch_kctrl", 16'hF004, 16'h0000);

        KEY = 4'b1011;
        cycle(12);
        peek("k2_kctrl", 16'hF004, 16'h0001);
        KEY = 4'b1001;
        found = 0;
        for (int i = 0; i < 24 && !found; i++) begin
            if (m_key_ev_next()) begin
                ADDR = 16'hF000; RE = 1;
                cycle();
                RE = 0;
                found = 1;
                peek("race_kctrl", 16'hF004, 16'h0001);
                peek("race_kdata", 16'hF000, 16'h0006);
            end else begin
                cycle();
            end
        end
        chk("race_found", 16'(found), 16'h1);

        KEY = 4'hF;
        SW = 10'h155;
        cycle(12);
        peek("sw_sdata", 16'hF010, 16'h0155);
        peek("sw_sctrl", 16'hF014, SWEV ? 16'h0001 : 16'h0000);
        ADDR = 16'hF014; WE = 1; DIN = 16'h0003;
        cycle();
        WE = 0;
        peek("sw_sctrl_w1c", 16'hF014, 16'h0000);
        peek("unmapped_dout", 16'h1000, 16'h0000);
        chk("unmapped_sel", SEL, 1'b0);

        SW = 10'h2AA;
        cycle(5);
        do_reset();
        peek("midrst_kdata", 16'hF000, 16'h0);
        peek("midrst_kctrl", 16'hF004, 16'h0);
        peek("midrst_sdata", 16'hF010, 16'h0);
        peek("midrst_sctrl", 16'hF014, 16'h0);
        SW = 10'h0;
        RESET_N = 1;
        cycle(12);
        peek("postrst_sdata", 16'hF010, 16'h0);
        peek("postrst_sctrl", 16'hF014, 16'h0);

        do_reset();
        SW = 10'h3FF;
        cycle(2);
        RESET_N = 1;
        cycle(12);
        peek("rstsw_sdata", 16'hF010, 16'h03FF);
        peek("rstsw_sctrl", 16'hF014, SWEV ? 16'h0001 : 16'h0000);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(11) == 0) KEY = 4'($urandom);
            if ($urandom_range(14) == 0) SW = 10'($urandom);
            ADDR = addrs[$urandom_range(7)];
            RE = ($urandom_range(3) == 0);
            WE = ($urandom_range(4) == 0);
            DIN = 16'($urandom);
            cycle();
            chk("rnd_dout", DOUT, m_rd(ADDR));
            chk("rnd_sel", 16'(SEL), 16'(m_sel(ADDR)));
        end
        RE = 0; WE = 0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
